recirc_ctrl: RTL
================

# recirc_ctrl

Moore-type controller that sequences the recirculation datapath of the physical-layer lanes. It takes configuration thresholds at init, tracks occupancy/error flags from the per-lane FIFOs, and drives `active` so the recirculation block forwards traffic only while the link is up. It also distributes the latched thresholds to the FIFOs and reports idle/error status upstream. Sits between the lane FIFOs and the recirculation block, clocked on `clk_2f`.

## Interface
- `N_FIFO`, 4: number of lane FIFOs monitored.
- `TH_W`, 4: width of the almost-empty/almost-full threshold fields.
- `IDLE_HOLD`, 2: consecutive all-empty cycles required to leave ACTIVE; range 1..15.
- `clk_2f`  input  1  single clock; all state changes on its rising edge.
- `reset_L`  input  1  asynchronous, active-low reset.
- `init`  input  1  request to (re)load thresholds.
- `umbral_bajo_in`  input  TH_W  requested almost-empty threshold.
- `umbral_alto_in`  input  TH_W  requested almost-full threshold.
- `fifo_empty`  input  N_FIFO  per-FIFO empty flag, bit i = FIFO i.
- `fifo_error`  input  N_FIFO  per-FIFO overflow/underflow flag.
- `active`  output  1  recirculation forward enable; 1 only in ACTIVE.
- `umbral_bajo_out`  output  TH_W  latched almost-empty threshold.
- `umbral_alto_out`  output  TH_W  latched almost-full threshold.
- `idle_out`  output  1  1 only in IDLE.
- `error_out`  output  1  1 only in ERROR.
- `cfg_err`  output  1  1 while in INIT with an invalid threshold pair.
- `state`  output  3  current state code.

## Operation
- States (binary): RESET=3'd0, INIT=3'd1, IDLE=3'd2, ACTIVE=3'd3, ERROR=3'd4; codes 5..7 go to RESET on the next edge.
- Transition priority, every state except RESET/ERROR: any `fifo_error` bit set -> ERROR; else `init`=1 -> INIT; else state-specific rule.
- RESET: unconditionally -> INIT on the first edge after `reset_L` deasserts.
- INIT: thresholds load every cycle in INIT from the `_in` ports. Pair valid iff `umbral_bajo_in` < `umbral_alto_in`. Exit to IDLE when `init`=0 and pair valid. Invalid pair: stay in INIT, `cfg_err`=1, outputs keep last valid values (no load).
- IDLE: any `fifo_empty` bit 0 -> ACTIVE.
- ACTIVE: hold counter `idle_cnt` (4 bits) increments each cycle all `fifo_empty` bits are 1; it clears on any non-empty cycle and on ACTIVE entry. When `idle_cnt` reaches IDLE_HOLD-1 with all empty this cycle -> IDLE.
- ERROR: sticky (see Configuration). `active`=0, thresholds retained.
- Outputs decode the state register only; no combinational input-to-output path.
- Reset values (asynchronous, while `reset_L`=0): `state`=RESET, `active`=0, `idle_out`=0, `error_out`=0, `cfg_err`=0, `umbral_bajo_out`=0, `umbral_alto_out`=0, `idle_cnt`=0.

## Timing
- Input sampled at edge k; new state and outputs visible after edge k (one-cycle latency).
- `reset_L` asserted mid-operation forces RESET immediately, without a clock; `active` drops asynchronously.
- Minimum path reset -> ACTIVE: RESET(1) + INIT(1, with `init`=0 and valid pair) + IDLE(1) -> ACTIVE on 3rd edge after release.
- ACTIVE -> IDLE: IDLE_HOLD consecutive all-empty edges; a non-empty sample at any point restarts the count.
- `fifo_error` and `init` together: ERROR wins. `init` and a non-empty FIFO in IDLE together: INIT wins.
- Thresholds change only on edges in INIT with a valid pair; stable in all other states.

## Configuration
- `RECIRC_CTRL_ERR_RECOVER_EN` defined: ERROR -> INIT when `init`=1 and `fifo_error`==0 on the same edge; `error_out` clears on that transition.
- Not defined: ERROR is left only by asserting `reset_L`=0; `init` ignored in ERROR.

## Test plan
- Reset release, `init`=0, `umbral_bajo_in`=2, `umbral_alto_in`=6, all empty -> state 0,1,2 on consecutive edges; thresholds out 2/6; `idle_out`=1, `active`=0.
- From IDLE, `fifo_empty`=4'b1101 -> `active`=1 next edge; then all empty for 2 cycles (IDLE_HOLD=2) -> IDLE; all empty 1 cycle then 4'b1110 -> stays ACTIVE.
- In INIT, bajo=7 alto=3 -> `cfg_err`=1, stay INIT, outputs hold prior values; change to bajo=1 alto=9 -> IDLE next edge, outputs 1/9.
- In ACTIVE, `fifo_error`=4'b0100 with `init`=1 -> ERROR, `error_out`=1, `active`=0; `init` pulse afterwards: stays ERROR without macro, -> INIT with macro.
- `reset_L` pulled low mid-ACTIVE between edges -> `active` and `state` reset immediately, thresholds 0.
- Force illegal state code 3'd6 (bench deposit) -> RESET on next edge.

Source files
------------

// File: rtl/recirc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : recirc_ctrl
// Purpose  : Moore controller sequencing the lane recirculation datapath;
//            latches FIFO thresholds and reports idle/error status upstream.
//            Optional macro RECIRC_CTRL_ERR_RECOVER_EN lets init leave ERROR.
// Revision : 1.0 - initial release
// ============================================================================
module recirc_ctrl #(
   parameter int N_FIFO    = 4,
   parameter int TH_W      = 4,
   parameter int IDLE_HOLD = 2
) (
   input  logic              clk_2f,
   input  logic              reset_L,
   input  logic              init,
   input  logic [TH_W-1:0]   umbral_bajo_in,
   input  logic [TH_W-1:0]   umbral_alto_in,
   input  logic [N_FIFO-1:0] fifo_empty,
   input  logic [N_FIFO-1:0] fifo_error,
   output logic              active,
   output logic [TH_W-1:0]   umbral_bajo_out,
   output logic [TH_W-1:0]   umbral_alto_out,
   output logic              idle_out,
   output logic              error_out,
   output logic              cfg_err,
   output logic [2:0]        state
);

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

   localparam logic [3:0] c_hold_last = 4'(IDLE_HOLD - 1);

   // Plain vector so unused codes 5..7 stay representable and recoverable.
   logic [2:0]      r_state;
   state_t          w_next;
   logic [3:0]      r_idle_cnt;
   logic [3:0]      w_idle_cnt_next;
   logic [TH_W-1:0] r_bajo;
   logic [TH_W-1:0] r_alto;
   logic            r_cfg_err;
   logic            w_pair_valid;
   logic            w_any_err;
   logic            w_all_empty;
   logic            w_load;

   assign w_pair_valid = (umbral_bajo_in < umbral_alto_in);
   assign w_any_err    = |fifo_error;
   assign w_all_empty  = &fifo_empty;
   assign w_load       = (r_state == ST_INIT) && w_pair_valid;

   always_comb begin
      w_next          = ST_RESET;
      w_idle_cnt_next = 4'd0;
      case (r_state)
         ST_RESET: w_next = ST_INIT;
         ST_INIT: begin
            if (w_any_err)
               w_next = ST_ERROR;
            else if (init || !w_pair_valid)
               w_next = ST_INIT;
            else
               w_next = ST_IDLE;
         end
         ST_IDLE: begin
            if (w_any_err)
               w_next = ST_ERROR;
            else if (init)
               w_next = ST_INIT;
            else if (!w_all_empty)
               w_next = ST_ACTIVE;
            else
               w_next = ST_IDLE;
         end
         ST_ACTIVE: begin
            if (w_any_err)
               w_next = ST_ERROR;
            else if (init)
               w_next = ST_INIT;
            else if (!w_all_empty)
               w_next = ST_ACTIVE;
            else if (r_idle_cnt == c_hold_last)
               w_next = ST_IDLE;
            else begin
               w_next          = ST_ACTIVE;
               w_idle_cnt_next = r_idle_cnt + 4'd1;
            end
         end
         ST_ERROR: begin
`ifdef RECIRC_CTRL_ERR_RECOVER_EN
            if (init && !w_any_err)
               w_next = ST_INIT;
            else
               w_next = ST_ERROR;
`else
            w_next = ST_ERROR;
`endif
         end
         default: w_next = ST_RESET;
      endcase
   end

   always_ff @(posedge clk_2f or negedge reset_L) begin
      if (!reset_L) begin
         r_state    <= ST_RESET;
         r_idle_cnt <= 4'd0;
         r_bajo     <= '0;
         r_alto     <= '0;
         r_cfg_err  <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_idle_cnt <= w_idle_cnt_next;
         // Registered so cfg_err remains a pure decode of stored state.
         r_cfg_err  <= (r_state == ST_INIT) && (w_next == ST_INIT) && !w_pair_valid;
         if (w_load) begin
            r_bajo <= umbral_bajo_in;
            r_alto <= umbral_alto_in;
         end
      end
   end

   assign active          = (r_state == ST_ACTIVE);
   assign idle_out        = (r_state == ST_IDLE);
   assign error_out       = (r_state == ST_ERROR);
   assign cfg_err         = r_cfg_err;
   assign umbral_bajo_out = r_bajo;
   assign umbral_alto_out = r_alto;
   assign state           = r_state;

endmodule
`default_nettype wire
